// File: rtl/vector_dispatch_queue.sv
// vector_dispatch_queue: buffers vector instructions from the scalar core, issues them to the vector unit and tracks completion
module vector_dispatch_queue #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         is_vector,
    input  logic [31:0]                  instruction,
    input  logic [31:0]                  rs1_data,
    input  logic [31:0]                  rs2_data,
    output logic                         scalar_stall,
    input  logic                         fence_req,
    output logic                         vec_valid,
    output logic [31:0]                  vec_instr,
    output logic [31:0]                  vec_rs1,
    output logic [31:0]                  vec_rs2,
    input  logic                         vec_ready,
    input  logic                         vec_done,
    output logic [$clog2(DEPTH):0]       q_count,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         vec_busy,
    output logic                         err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          full;
    logic          enq;
    logic          deq;
    logic          ret;
    logic          bad;

    assign full         = q_count == CW'(DEPTH);
    assign vec_busy     = q_count != '0 || outstanding != '0;
    assign scalar_stall = (is_vector && full) || (fence_req && vec_busy);
    assign vec_valid    = q_count != '0 && outstanding < OW'(MAX_OUT);
    assign enq          = is_vector && !full && !fence_req;
    assign deq          = vec_valid && vec_ready;
    assign ret          = vec_done && outstanding != '0;
    assign bad          = (is_vector && fence_req) || (vec_done && outstanding == '0);
    assign {vec_instr, vec_rs1, vec_rs2} = mem[head];

    // pointers, occupancy, in-flight count and sticky error
    always_ff @(posedge clk) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            q_count     <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            head        <= head + AW'(deq);
            tail        <= tail + AW'(enq);
            q_count     <= q_count + CW'(enq) - CW'(deq);
            outstanding <= outstanding + OW'(deq) - OW'(ret);
            err         <= err | bad;
        end
    end

    // payload storage is never reset; it is only meaningful while vec_valid is high
    always_ff @(posedge clk) begin
        if (enq) mem[tail] <= {instruction, rs1_data, rs2_data};
    end
endmodule

// File: tb/tb_vector_dispatch_queue.sv
// tb_vector_dispatch_queue: directed and random stimulus against a queue-based reference model with a payload scoreboard
module tb_vector_dispatch_queue;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 0, rst = 0, is_vector = 0, fence_req = 0, vec_ready = 0, vec_done = 0;
    logic [31:0] instruction = 0, rs1_data = 0, rs2_data = 0;
    logic        scalar_stall, vec_valid, vec_busy, err;
    logic [31:0] vec_instr, vec_rs1, vec_rs2;
    logic [$clog2(DEPTH):0]       q_count;
    logic [$clog2(MAX_OUT+1)-1:0] outstanding;

    typedef struct {logic [31:0] i, a, b;} ent_t;
    ent_t sb[$];
    int   m_cnt = 0, m_out = 0;
    bit   m_err = 0;
    int   n_chk = 0, n_fail = 0;

    vector_dispatch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .is_vector(is_vector), .instruction(instruction),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .scalar_stall(scalar_stall),
        .fence_req(fence_req), .vec_valid(vec_valid), .vec_instr(vec_instr),
        .vec_rs1(vec_rs1), .vec_rs2(vec_rs2), .vec_ready(vec_ready), .vec_done(vec_done),
        .q_count(q_count), .outstanding(outstanding), .vec_busy(vec_busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // one cycle: drive inputs, compare outputs with the model, then advance the model
    task automatic step(input bit r, iv, input logic [31:0] ins, a, b, input bit fr, rdy, dn);
        bit full, busy, vv, deq, enq, rt;
        @(negedge clk);
        rst = r; is_vector = iv; instruction = ins; rs1_data = a; rs2_data = b;
        fence_req = fr; vec_ready = rdy; vec_done = dn;
        #1;
        full = m_cnt == DEPTH;
        busy = m_cnt != 0 || m_out != 0;
        vv   = m_cnt != 0 && m_out < MAX_OUT;
        chk("scalar_stall", 32'(scalar_stall), 32'((iv && full) || (fr && busy)));
        chk("vec_valid", 32'(vec_valid), 32'(vv));
        chk("vec_busy", 32'(vec_busy), 32'(busy));
        chk("q_count", 32'(q_count), m_cnt);
        chk("outstanding", 32'(outstanding), m_out);
        chk("err", 32'(err), 32'(m_err));
        if (!r) begin
            m_cnt = 0; m_out = 0; m_err = 0; sb.delete();
        end else begin
            deq   = vv && rdy;
            enq   = iv && !full && !fr;
            rt    = dn && m_out > 0;
            m_err = m_err || (iv && fr) || (dn && m_out == 0);
            m_out = m_out + int'(deq) - int'(rt);
            m_cnt = m_cnt + int'(enq) - int'(deq);
            if (enq) sb.push_back('{ins, a, b});
        end
    endtask

    task automatic idle(input bit rdy, dn);
        step(1, 0, 0, 0, 0, 0, rdy, dn);
    endtask

    // monitor: every handshake must deliver the oldest expected entry
    initial forever begin
        ent_t e;
        @(negedge clk);
        #1;
        if (rst && vec_valid && vec_ready) begin
            if (sb.size() == 0) chk("handshake_with_empty_scoreboard", 32'(vec_valid), 0);
            else begin
                e = sb.pop_front();
                chk("vec_instr", vec_instr, e.i);
                chk("vec_rs1", vec_rs1, e.a);
                chk("vec_rs2", vec_rs2, e.b);
            end
        end
    end

    initial begin
        bit r, iv, fr, rdy, dn;
        repeat (2) @(posedge clk);
        step(1, 1, 32'h0200_7057, 32'h10, 32'h20, 0, 1, 0);
        idle(1, 0);
        idle(0, 1);
        idle(0, 0);
        for (int k = 0; k < 5; k++) step(1, 1, 32'hA0 + k, k, ~k, 0, 0, 0);
        step(1, 1, 32'hA4, 4, ~4, 0, 1, 0);
        step(1, 1, 32'hA4, 4, ~4, 0, 0, 0);
        repeat (4) idle(1, 0);
        repeat (3) idle(1, 1);
        step(1, 1, 32'hB0, 1, 2, 0, 1, 1);
        step(1, 1, 32'hB1, 3, 4, 0, 1, 0);
        idle(1, 1);
        repeat (2) idle(1, 0);
        repeat (2) step(1, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        idle(0, 1);
        idle(0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 32'hC0 + k, k, k, 0, 0, 0);
        repeat (2) idle(1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(0, 0);
        repeat (3000) begin
            r   = $urandom_range(99) != 0;
            iv  = $urandom_range(2) == 0;
            fr  = iv ? $urandom_range(199) == 0 : $urandom_range(9) == 0;
            rdy = $urandom_range(1) == 1;
            dn  = m_out > 0 ? $urandom_range(2) != 0 : $urandom_range(29) == 0;
            step(r, iv, $urandom, $urandom, $urandom, fr, rdy, dn);
        end
        idle(0, 0);
        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
